// File: rtl/lpif_rx_state_ctrl.sv
// LPIF receive-side state controller: LPIF state status, RX datapath gating and flush/EDB pulses.
// Optional handshake timeout enabled by defining LPIF_RX_CTRL_TIMEOUT_EN.
module lpif_rx_state_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       link_up,
    input  logic       ltssm_recovery,
    input  logic [3:0] lp_state_req,
    input  logic       lp_linkerror,
    input  logic       rx_pkt_open,
    output logic [3:0] pl_state_sts,
    output logic       rx_dp_en,
    output logic       rx_dp_flush,
    output logic       rx_force_edb,
    output logic       ltssm_force_detect,
    output logic       pl_trainerror
);

    typedef enum logic [3:0] {
        ST_RESET     = 4'h0,
        ST_ACTIVE    = 4'h1,
        ST_LINKERROR = 4'hA,
        ST_RETRAIN   = 4'hB
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t state;
    state_t state_nxt;
    logic   timeout_hit;
    logic   leave_active;
    logic   dp_en_q;
    logic   flush_q;
    logic   edb_q;
    logic   detect_q;
    logic   dp_en_nxt;
    logic   flush_nxt;
    logic   edb_nxt;
    logic   detect_nxt;

    always_comb begin
        state_nxt = state;
        if (lp_linkerror) begin
            state_nxt = ST_LINKERROR;
        end else begin
            unique case (state)
                ST_RESET: begin
                    if (link_up && lp_state_req == 4'h1)
                        state_nxt = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (!link_up)
                        state_nxt = ST_RESET;
                    else if (ltssm_recovery)
                        state_nxt = ST_RETRAIN;
                end
                ST_RETRAIN: begin
                    if (timeout_hit)
                        state_nxt = ST_LINKERROR;
                    else if (!link_up)
                        state_nxt = ST_RESET;
                    else if (!ltssm_recovery)
                        state_nxt = ST_ACTIVE;
                end
                ST_LINKERROR: begin
                    if (lp_state_req == 4'h0)
                        state_nxt = ST_RESET;
                end
                default: state_nxt = ST_RESET;
            endcase
        end
    end

    // Outputs are derived from the next state so they land on the transition edge.
    always_comb begin
        leave_active = (state == ST_ACTIVE) && (state_nxt != ST_ACTIVE);
        dp_en_nxt    = (state_nxt == ST_ACTIVE);
        flush_nxt    = leave_active;
        edb_nxt      = leave_active && rx_pkt_open;
        detect_nxt   = (state_nxt == ST_LINKERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_RESET;
            dp_en_q  <= 1'b0;
            flush_q  <= 1'b0;
            edb_q    <= 1'b0;
            detect_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            dp_en_q  <= dp_en_nxt;
            flush_q  <= flush_nxt;
            edb_q    <= edb_nxt;
            detect_q <= detect_nxt;
        end
    end

    assign pl_state_sts       = state;
    assign rx_dp_en           = dp_en_q;
    assign rx_dp_flush        = flush_q;
    assign rx_force_edb       = edb_q;
    assign ltssm_force_detect = detect_q;

`ifdef LPIF_RX_CTRL_TIMEOUT_EN
    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    logic [15:0] timer;
    logic [15:0] timer_nxt;
    logic        count_en;
    logic        trainerror_q;
    logic        trainerror_nxt;

    always_comb begin
        count_en = ((state == ST_RESET) && link_up && (lp_state_req != 4'h1))
                 || (state == ST_RETRAIN);
        // The cycle whose count reaches TMO is the one that forces the exit.
        timeout_hit = (state == ST_RETRAIN) && (timer == TMO - 16'd1);
        timer_nxt = 16'd0;
        if (count_en && state_nxt == state) begin
            if (timer != TMO)
                timer_nxt = timer + 16'd1;
            else
                timer_nxt = timer;
        end
        trainerror_nxt = (state_nxt == ST_RESET)
                       && (trainerror_q || timer_nxt == TMO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer        <= 16'd0;
            trainerror_q <= 1'b0;
        end else begin
            timer        <= timer_nxt;
            trainerror_q <= trainerror_nxt;
        end
    end

    assign pl_trainerror = trainerror_q;
`else
    assign timeout_hit   = 1'b0;
    assign pl_trainerror = 1'b0;
`endif

endmodule

// File: tb/tb_lpif_rx_state_ctrl.sv
// Scoreboard bench for lpif_rx_state_ctrl: directed scenarios then random traffic.
// Expected outputs are queued by the driver and checked by an independent monitor.
module tb_lpif_rx_state_ctrl;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       link_up = 1'b0;
    logic       ltssm_recovery = 1'b0;
    logic [3:0] lp_state_req = 4'h0;
    logic       lp_linkerror = 1'b0;
    logic       rx_pkt_open = 1'b0;
    logic [3:0] pl_state_sts;
    logic       rx_dp_en;
    logic       rx_dp_flush;
    logic       rx_force_edb;
    logic       ltssm_force_detect;
    logic       pl_trainerror;

    lpif_rx_state_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                (clk),
        .reset              (reset),
        .link_up            (link_up),
        .ltssm_recovery     (ltssm_recovery),
        .lp_state_req       (lp_state_req),
        .lp_linkerror       (lp_linkerror),
        .rx_pkt_open        (rx_pkt_open),
        .pl_state_sts       (pl_state_sts),
        .rx_dp_en           (rx_dp_en),
        .rx_dp_flush        (rx_dp_flush),
        .rx_force_edb       (rx_force_edb),
        .ltssm_force_detect (ltssm_force_detect),
        .pl_trainerror      (pl_trainerror)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sts;
        logic       en;
        logic       flush;
        logic       edb;
        logic       det;
        logic       te;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;

    // Reference model: LPIF state value, cycles spent counting, trainerror flag.
    int   m_st = 0;
    int   m_cnt = 0;
    bit   m_te = 1'b0;

    function automatic exp_t dut_out();
        return {pl_state_sts, rx_dp_en, rx_dp_flush, rx_force_edb,
                ltssm_force_detect, pl_trainerror};
    endfunction

    task automatic compare(input string name, input exp_t a, input exp_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cycle=%0d got sts=%h en=%b fl=%b edb=%b det=%b te=%b want sts=%h en=%b fl=%b edb=%b det=%b te=%b",
                     name, cycle, a.sts, a.en, a.flush, a.edb, a.det, a.te,
                     e.sts, e.en, e.flush, e.edb, e.det, e.te);
        end
    endtask

    task automatic model(input bit lu, input bit rec, input logic [3:0] req,
                         input bit lerr, input bit open, output exp_t e);
        int nst;
        bit hit;
        nst = m_st;
        hit = 1'b0;
`ifdef LPIF_RX_CTRL_TIMEOUT_EN
        hit = (m_st == 11) && (m_cnt + 1 >= TO);
`endif
        if (lerr) nst = 10;
        else if (m_st == 0) begin
            if (lu && req == 4'h1) nst = 1;
        end else if (m_st == 1) begin
            if (!lu) nst = 0;
            else if (rec) nst = 11;
        end else if (m_st == 11) begin
            if (hit) nst = 10;
            else if (!lu) nst = 0;
            else if (!rec) nst = 1;
        end else begin
            if (req == 4'h0) nst = 0;
        end
`ifdef LPIF_RX_CTRL_TIMEOUT_EN
        if (nst != m_st || !((m_st == 0 && lu && req != 4'h1) || m_st == 11))
            m_cnt = 0;
        else if (m_cnt < TO)
            m_cnt++;
        m_te = (nst == 0) && (m_te || m_cnt == TO);
`endif
        e.sts   = 4'(nst);
        e.en    = (nst == 1);
        e.flush = (m_st == 1) && (nst != 1);
        e.edb   = e.flush && open;
        e.det   = (nst == 10);
        e.te    = m_te;
        m_st = nst;
    endtask

    task automatic cyc(input bit lu, input bit rec, input logic [3:0] req,
                       input bit lerr, input bit open);
        exp_t e;
        @(negedge clk);
        cycle++;
        reset = 1'b0;
        link_up = lu;
        ltssm_recovery = rec;
        lp_state_req = req;
        lp_linkerror = lerr;
        rx_pkt_open = open;
        model(lu, rec, req, lerr, open, e);
        q.push_back(e);
    endtask

    task automatic rst_cyc();
        @(negedge clk);
        cycle++;
        #2 reset = 1'b1;
        #1 compare("async_reset", dut_out(), exp_t'(0));
        m_st = 0;
        m_cnt = 0;
        m_te = 1'b0;
        q.push_back(exp_t'(0));
    endtask

    task automatic rand_cyc();
        int r;
        logic [3:0] req;
        r = $urandom_range(0, 9);
        if (r < 4) req = 4'h1;
        else if (r < 7) req = 4'h0;
        else req = 4'($urandom_range(2, 15));
        cyc($urandom_range(0, 99) < 90, $urandom_range(0, 99) < 25, req,
            $urandom_range(0, 99) < 4, $urandom_range(0, 1) == 1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                compare("out", dut_out(), mon_e);
            end
        end
    end

    initial begin
        rst_cyc();
        rst_cyc();
        for (int i = 0; i < 5; i++) cyc(1, 0, 4'h0, 0, 0);
        cyc(1, 0, 4'h1, 0, 0);
        cyc(1, 0, 4'h1, 0, 1);
        cyc(1, 1, 4'h5, 0, 1);
        cyc(1, 1, 4'h5, 0, 1);
        cyc(1, 0, 4'h5, 0, 0);
        cyc(1, 1, 4'h1, 0, 0);
        cyc(1, 0, 4'h1, 0, 1);
        cyc(0, 1, 4'h1, 1, 0);
        cyc(1, 0, 4'h3, 0, 0);
        cyc(1, 0, 4'h0, 1, 0);
        cyc(1, 0, 4'h0, 0, 0);
        cyc(1, 0, 4'h2, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 0, 4'h0, 0, 0);
        cyc(0, 0, 4'h0, 0, 0);
        cyc(1, 0, 4'h1, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 1, 4'h1, 0, 0);
        cyc(1, 0, 4'h0, 0, 0);
        cyc(1, 0, 4'h0, 0, 0);
        cyc(1, 0, 4'h1, 0, 0);
        cyc(1, 0, 4'h1, 0, 0);
        cyc(1, 1, 4'h1, 0, 1);
        rst_cyc();
        cyc(1, 0, 4'h0, 0, 0);
        cyc(1, 0, 4'h0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) rst_cyc();
            else rand_cyc();
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain left=%0d want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
